// File: rtl/simon_seq_ctrl_if.sv
// Signal bundle between the Simon sequencer and its neighbours (random source,
// button encoder, lamp/display drivers); the sequencer sits on the slave side.
interface simon_seq_ctrl_if #(
  parameter int LW = 6
);
  logic          start;
  logic [1:0]    rand_in;
  logic          btn_valid;
  logic [1:0]    btn_code;
  logic          lamp_en;
  logic [1:0]    lamp_code;
  logic          input_ready;
  logic [LW-1:0] level;
  logic          win;
  logic          lose;
  logic          busy;
  // Encoded controller state, exposed for observation only.
  logic [2:0]    state;

  modport master (
    output start, rand_in, btn_valid, btn_code,
    input  lamp_en, lamp_code, input_ready, level, win, lose, busy, state
  );

  modport slave (
    input  start, rand_in, btn_valid, btn_code,
    output lamp_en, lamp_code, input_ready, level, win, lose, busy, state
  );
endinterface

// File: rtl/simon_seq_ctrl.sv
// Simon Says game sequencer: grows a colour pattern one element per round,
// replays it on the lamp with fixed lit/dark timing, then checks player presses.
//
// start and btn_valid are single-cycle pulses with no back-pressure: the
// controller acts on start only in IDLE/WIN/LOSE and on btn_valid only in
// INPUT (where input_ready is high); pulses arriving elsewhere are dropped.
module simon_seq_ctrl #(
  parameter int MAX_LEN     = 32,
  parameter int SHOW_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 12_500_000,
  parameter int LW          = $clog2(MAX_LEN + 1),
  parameter int CW          = $clog2(((SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES) + 1)
) (
  input  logic clk,
  input  logic rst,
  simon_seq_ctrl_if.slave bus
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [CW-1:0] SHOW_LOAD = CW'(SHOW_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
  localparam logic [LW-1:0] LEN_MAX   = LW'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADD      = 3'd1,
    S_SHOW_ON  = 3'd2,
    S_SHOW_OFF = 3'd3,
    S_INPUT    = 3'd4,
    S_WIN      = 3'd5,
    S_LOSE     = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [CW-1:0] timer_q, timer_d;
  logic          mem_we;
  logic [1:0]    mem [MAX_LEN];
  logic [1:0]    cur_color;
  logic          last_elem;

  // idx and len stay below MAX_LEN whenever mem is addressed, so the low bits suffice.
  assign cur_color = mem[idx_q[AW-1:0]];
  assign last_elem = (idx_q == (len_q - LW'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
    end
  end

  // Pattern memory survives both start and reset; only len marks valid entries.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[len_q[AW-1:0]] <= bus.rand_in;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    mem_we  = 1'b0;

    case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        if (bus.start) begin
          len_d   = '0;
          idx_d   = '0;
          timer_d = '0;
          state_d = S_ADD;
        end
      end

      S_ADD: begin
        mem_we  = 1'b1;
        len_d   = len_q + LW'(1);
        idx_d   = '0;
        timer_d = SHOW_LOAD;
        state_d = S_SHOW_ON;
      end

      S_SHOW_ON: begin
        if (timer_q == '0) begin
          timer_d = GAP_LOAD;
          state_d = S_SHOW_OFF;
        end else begin
          timer_d = timer_q - CW'(1);
        end
      end

      S_SHOW_OFF: begin
        if (timer_q == '0) begin
          if (last_elem) begin
            idx_d   = '0;
            state_d = S_INPUT;
          end else begin
            idx_d   = idx_q + LW'(1);
            timer_d = SHOW_LOAD;
            state_d = S_SHOW_ON;
          end
        end else begin
          timer_d = timer_q - CW'(1);
        end
      end

      S_INPUT: begin
        if (bus.btn_valid) begin
          if (bus.btn_code != cur_color) begin
            state_d = S_LOSE;
          end else if (!last_elem) begin
            idx_d = idx_q + LW'(1);
          end else if (len_q == LEN_MAX) begin
            state_d = S_WIN;
          end else begin
            state_d = S_ADD;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Every output is a decode of registered state, so reset clears them at once.
  assign bus.lamp_en     = (state_q == S_SHOW_ON);
  assign bus.lamp_code   = (state_q == S_SHOW_ON) ? cur_color : 2'b00;
  assign bus.input_ready = (state_q == S_INPUT);
  assign bus.level       = len_q;
  assign bus.win         = (state_q == S_WIN);
  assign bus.lose        = (state_q == S_LOSE);
  assign bus.busy        = (state_q != S_IDLE) && (state_q != S_WIN) && (state_q != S_LOSE);
  assign bus.state       = state_q;

endmodule

// File: doc/simon_seq_ctrl.md
# simon_seq_ctrl

Game sequencer for the Simon Says datapath. It captures one 2-bit colour from the free-running random sequence generator per round and stores the growing pattern. It replays the pattern on the lamp outputs with fixed on/gap timing, then checks player button presses against it. It sits between the random sequence generator, the debounced button encoder and the lamp/display drivers.

## Interface
- MAX_LEN, 32: maximum pattern length; reaching it wins the game (≥2).
- SHOW_CYCLES, 25_000_000: cycles each lamp stays lit during playback (≥1).
- GAP_CYCLES, 12_500_000: dark cycles after each lit lamp (≥1).
- LW, $clog2(MAX_LEN+1): width of level.
- CW, $clog2(max(SHOW_CYCLES,GAP_CYCLES)+1): width of the internal phase timer.

- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; starts a new game.
- rand_in  in  2  colour from the random sequence generator, sampled only in ADD.
- btn_valid  in  1  single-cycle pulse; a player press is present.
- btn_code  in  2  colour of the press, qualified by btn_valid.
- lamp_en  out  1  lamp lit.
- lamp_code  out  2  colour to light; 0 when lamp_en=0.
- input_ready  out  1  controller is waiting for player presses.
- level  out  LW  current pattern length.
- win  out  1  held high after MAX_LEN rounds are completed.
- lose  out  1  held high after a wrong press.
- busy  out  1  high in every state except IDLE, WIN and LOSE.

## Operation
- Pattern storage: MAX_LEN×2-bit register array mem, plus length register len and index register idx.
- States: IDLE, ADD, SHOW_ON, SHOW_OFF, INPUT, WIN, LOSE.
- IDLE/WIN/LOSE with start=1:
  - clear len, idx, win and lose;
  - go to ADD.
- ADD, one cycle:
  - mem[len] ← rand_in, len ← len+1, idx ← 0;
  - load the timer;
  - go to SHOW_ON.
- SHOW_ON:
  - lamp_en=1, lamp_code=mem[idx];
  - after SHOW_CYCLES cycles, go to SHOW_OFF.
- SHOW_OFF:
  - lamp dark;
  - after GAP_CYCLES cycles: if idx==len-1, set idx←0 and go to INPUT; else idx←idx+1 and go to SHOW_ON.
- INPUT:
  - input_ready=1.
  - On btn_valid with btn_code≠mem[idx]: go to LOSE.
  - On a match with idx<len-1: idx←idx+1.
  - On a match with idx==len-1: go to WIN if len==MAX_LEN, else go to ADD.
- WIN/LOSE: hold the flag until start or rst.
- start is ignored in ADD, SHOW_ON, SHOW_OFF and INPUT.
- btn_valid is ignored outside INPUT, including presses during playback.
- level = len, unsigned, never exceeds MAX_LEN; mem index never wraps.
- mem contents are not cleared on start; only len is cleared.

## Timing
- Reset values: state=IDLE; len=0, idx=0, timer=0; all outputs 0.
- Reset mid-game aborts immediately and asynchronously. The next game requires a start pulse.
- start at edge E puts ADD in the cycle after E. The first SHOW_ON cycle follows one cycle later.
- All outputs are registered, or decoded from registered state only.
- For round length n, the playback phase lasts exactly n×(SHOW_CYCLES+GAP_CYCLES) cycles from the first SHOW_ON cycle to the first INPUT cycle.
- lamp_en is high for exactly SHOW_CYCLES consecutive cycles per element.
- The press check uses btn_code in the same cycle as btn_valid. The state, win and lose change at the next edge.
- input_ready drops in the cycle after the deciding press.
- After the final correct press: ADD on the next cycle, level increments one cycle later.
- start arriving in the same cycle as a deciding press in INPUT is ignored.

## Test plan
Parameters for all scenarios: MAX_LEN=3, SHOW_CYCLES=4, GAP_CYCLES=2.

- Reset during SHOW_ON with lamp lit → lamp_en, level, busy, win and lose all read 0 in the same cycle; state returns to IDLE.
- start with rand_in=2'b10 → ADD 1 cycle later, level=1 one cycle after that, then lamp_en=1 with lamp_code=2 for 4 cycles, dark for 2 cycles, then input_ready=1.
- Round 1 =2, press btn_code=2 → round 2 adds rand_in=1. Playback shows 2 then 1, 12 cycles total. Presses 2,1 → level=3.
- Complete all 3 rounds correctly → win=1, busy=0, level=3. win stays high until start, then clears with level back to 0.
- Wrong press (btn_code=0 when mem[0]=3) → lose=1 next cycle, input_ready=0. Further btn_valid pulses change nothing.
- btn_valid pulses during SHOW_ON/SHOW_OFF, and start pulses during INPUT → no state change, playback timing unchanged.
